// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared defaults and state codes for the SRAM port arbiter
package sram_port_arbiter_pkg;

    localparam int          DEF_ADDR_W     = 16;
    localparam int          DEF_DATA_W     = 8;
    localparam logic [7:0]  DEF_INIT_VALUE = 8'h00;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// rtl/sram_port_arbiter_rr_arb2.sv - two-way round-robin arbiter remembering the last winner
module sram_port_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // rr_last resets to 1 so master 0 wins the first tie
    logic rr_last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (|grant) begin
            rr_last <= grant[1];
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-master SRAM arbiter with read return path and memory-init engine
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = DEF_INIT_VALUE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_valid,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_req_ready,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_data,
    input  logic              m1_req_valid,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_req_ready,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_data,
    input  logic              init_start,
    output logic              init_busy,
    output logic              init_done,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [1:0]        rd_pend;
    logic [1:0]        grant;
    logic              init_done_q;
    logic              arb_en;
    logic              init_last;

    // Gating with rst_n keeps the readies low while reset is held, whatever the masters drive
    assign arb_en    = (state == ST_ARB) && rst_n;
    assign init_last = (init_cnt == {ADDR_W{1'b1}});

    sram_port_arbiter_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({m1_req_valid, m0_req_valid}),
        .grant (grant)
    );

    always_comb begin
        state_nxt  = state;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            ST_ARB: begin
                if (init_start) begin
                    state_nxt = ST_INIT;
                end
                if (grant[0]) begin
                    sram_we    = m0_req_we;
                    sram_addr  = m0_req_addr;
                    sram_wdata = m0_req_wdata;
                end else if (grant[1]) begin
                    sram_we    = m1_req_we;
                    sram_addr  = m1_req_addr;
                    sram_wdata = m1_req_wdata;
                end
            end
            ST_INIT: begin
                sram_we    = 1'b1;
                sram_addr  = init_cnt;
                sram_wdata = INIT_VALUE;
                if (init_last) begin
                    state_nxt = ST_ARB;
                end
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ARB;
            init_cnt    <= '0;
            rd_pend     <= 2'b00;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_cnt    <= ((state == ST_INIT) && !init_last) ? init_cnt + ADDR_ONE : '0;
            rd_pend     <= {grant[1] & ~m1_req_we, grant[0] & ~m0_req_we};
            init_done_q <= (state == ST_INIT) && init_last;
        end
    end

    // The SRAM output register already gives the one-cycle read latency
    assign m0_req_ready = grant[0];
    assign m1_req_ready = grant[1];
    assign m0_rsp_valid = rd_pend[0];
    assign m1_rsp_valid = rd_pend[1];
    assign m0_rsp_data  = sram_rdata;
    assign m1_rsp_data  = sram_rdata;
    assign init_busy    = (state == ST_INIT);
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter with behavioural SRAM and reference model
module tb_sram_port_arbiter;

    localparam logic [7:0] INIT_VAL = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_we, m0_req_ready, m0_rsp_valid;
    logic [15:0] m0_req_addr;
    logic [7:0]  m0_req_wdata, m0_rsp_data;
    logic        m1_req_valid, m1_req_we, m1_req_ready, m1_rsp_valid;
    logic [15:0] m1_req_addr;
    logic [7:0]  m1_req_wdata, m1_rsp_data;
    logic        init_start, init_busy, init_done;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata = 8'h00;

    sram_port_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_req_ready (m0_req_ready),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_data  (m0_rsp_data),
        .m1_req_valid (m1_req_valid),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_req_ready (m1_req_ready),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_data  (m1_rsp_data),
        .init_start   (init_start),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM: registered read, output holds during writes
    logic [7:0] sram_mem [65536];
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        else         sram_rdata <= sram_mem[sram_addr];
    end

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rsp_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] ref_mem [65536];
    rsp_t       q0[$];
    rsp_t       q1[$];
    int         grant_log[$];
    int         m_last   = 1;
    bit         m_init   = 0;
    int         m_cnt    = 0;
    bit         m_done   = 0;
    int         init_err = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rsp(int n, logic v, logic [7:0] d);
        rsp_t e;
        int   sz;
        sz = (n == 0) ? q0.size() : q1.size();
        if (sz != 0) begin
            e = (n == 0) ? q0[0] : q1[0];
            if (e.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL rsp%0d_missing: no response, expected data %0h at cycle %0d", n, e.data, e.cyc);
                if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                sz--;
            end
        end
        if (v) begin
            if (sz == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp%0d_unexpected: got valid data %0h, expected no response", n, d);
            end else begin
                e = (n == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("rsp%0d_cycle", n), 64'(cyc), 64'(e.cyc));
                check($sformatf("rsp%0d_data", n), 64'(d), 64'(e.data));
            end
        end
    endtask

    // Monitor: reference model of arbitration, memory contents and init sweep
    always @(negedge clk) begin
        int         g;
        logic [1:0] er;
        logic       ew;
        logic [15:0] ea;
        logic [7:0]  ed;
        rsp_t        e;
        cyc++;
        if (!rst_n) begin
            check("reset_outs", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                                 init_busy, init_done, sram_we}, 0);
            check("reset_bus", {sram_addr, sram_wdata}, 0);
            m_last = 1; m_init = 0; m_cnt = 0; m_done = 0; init_err = 0;
            q0.delete(); q1.delete();
        end else begin
            check_rsp(0, m0_rsp_valid, m0_rsp_data);
            check_rsp(1, m1_rsp_valid, m1_rsp_data);
            check("init_done", 64'(init_done), 64'(m_done));
            m_done = 0;
            if (m_init) begin
                if (init_busy !== 1'b1 || m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0 ||
                    sram_we !== 1'b1 || sram_addr !== 16'(m_cnt) || sram_wdata !== INIT_VAL)
                    init_err++;
                ref_mem[m_cnt] = INIT_VAL;
                if (m_cnt == 65535) begin
                    check("init_seq_errors", 64'(init_err), 0);
                    init_err = 0; m_init = 0; m_cnt = 0; m_done = 1;
                end else begin
                    m_cnt++;
                end
            end else begin
                check("init_busy_arb", 64'(init_busy), 0);
                g = -1;
                if (m0_req_valid && m1_req_valid) g = (m_last == 0) ? 1 : 0;
                else if (m0_req_valid)            g = 0;
                else if (m1_req_valid)            g = 1;
                er = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
                check("grant", {m1_req_ready, m0_req_ready}, 64'(er));
                if (m0_req_ready) grant_log.push_back(0);
                if (m1_req_ready) grant_log.push_back(1);
                ew = 1'b0; ea = 16'h0; ed = 8'h0;
                if (g == 0) begin ew = m0_req_we; ea = m0_req_addr; ed = m0_req_wdata; end
                if (g == 1) begin ew = m1_req_we; ea = m1_req_addr; ed = m1_req_wdata; end
                check("sram_bus", {sram_we, sram_addr, sram_wdata}, {ew, ea, ed});
                if (g >= 0) begin
                    m_last = g;
                    if (ew) begin
                        ref_mem[ea] = ed;
                    end else begin
                        e.cyc  = cyc + 1;
                        e.data = ref_mem[ea];
                        if (g == 0) q0.push_back(e); else q1.push_back(e);
                    end
                end
                if (init_start) m_init = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        m0_req_valid = 0; m0_req_we = 0; m0_req_addr = 0; m0_req_wdata = 0;
        m1_req_valid = 0; m1_req_we = 0; m1_req_addr = 0; m1_req_wdata = 0;
        init_start   = 0;
    endtask

    task automatic rand_req();
        m0_req_valid = 1'($urandom_range(0, 1));
        m0_req_we    = 1'($urandom_range(0, 1));
        m0_req_addr  = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        m0_req_wdata = 8'($urandom);
        m1_req_valid = 1'($urandom_range(0, 1));
        m1_req_we    = 1'($urandom_range(0, 1));
        m1_req_addr  = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        m1_req_wdata = 8'($urandom);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        rst_n = 0;
        clear_in();

        // Reset held with random inputs
        repeat (10) begin
            step();
            rand_req();
            init_start = 1'($urandom_range(0, 1));
        end
        step();
        clear_in();
        rst_n = 1;

        // Write then read of the same address by the other master
        step();
        m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 16'h1234; m0_req_wdata = 8'hA5;
        step();
        m0_req_valid = 0;
        m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 16'h1234;
        step();
        m1_req_valid = 0;
        check("t2_m1_rsp", {m1_rsp_valid, m1_rsp_data}, {1'b1, 8'hA5});
        check("t2_m0_rsp", 64'(m0_rsp_valid), 0);

        // Alternating grants from reset with both masters reading
        rst_n = 0;
        step();
        rst_n = 1;
        grant_log.delete();
        repeat (4) begin
            m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 16'($urandom);
            m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 16'($urandom);
            step();
        end
        clear_in();
        check("t3_grant_count", 64'(grant_log.size()), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("t3_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Random traffic
        repeat (1500) begin
            rand_req();
            step();
        end
        clear_in();
        step();

        // Init aborted by reset at counter 0x100
        init_start = 1;
        step();
        init_start = 0;
        repeat (256) begin
            rand_req();
            step();
        end
        clear_in();
        rst_n = 0;
        #1;
        check("t5_busy_abort", 64'(init_busy), 0);
        step();
        rst_n = 1;
        m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 16'h0042;
        #1;
        check("t5_first_grant", {m1_req_ready, m0_req_ready}, 2'b01);
        step();
        clear_in();
        step();

        // Full init, started alongside a granted read
        m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 16'h0000; m0_req_wdata = 8'hFF;
        step();
        m0_req_addr = 16'hFFFF;
        step();
        m0_req_we = 0; init_start = 1;
        step();
        clear_in();
        check("t6_rsp", {m0_rsp_valid, m0_rsp_data}, {1'b1, 8'hFF});
        check("t6_init_busy", 64'(init_busy), 1);
        n = 0;
        while (init_busy === 1'b1 && n < 70000) begin
            n++;
            step();
            rand_req();
        end
        check("t4_busy_len", 64'(n), 65536);
        check("t4_init_done", 64'(init_done), 1);
        step();
        clear_in();
        check("t4_done_pulse", 64'(init_done), 0);
        m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 16'h0000;
        step();
        clear_in();
        m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 16'hFFFF;
        check("t4_rd0", {m0_rsp_valid, m0_rsp_data}, {1'b1, INIT_VAL});
        step();
        clear_in();
        check("t4_rdffff", {m1_rsp_valid, m1_rsp_data}, {1'b1, INIT_VAL});
        repeat (3) step();
        check("q_drain", 64'(q0.size() + q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
